mul_seq: RTL and testbench

- Iterative radix-2 shift-add multiply engine with its own control FSM.
- Executes the DP MUL (ALUControl 3'b100) over several cycles instead of as a single-cycle combinational multiplier.
- Sits beside the ALU. The main control FSM pulses start, holds in its execute state while busy=1, and writes product back on done.
- Also supplies the N/Z flags for MULS.

---
 rtl/mul_seq.sv | 116 +++++++++++
 tb/tb_mul_seq.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/mul_seq.sv
// Iterative radix-2 shift-add multiplier returning the low WIDTH bits of a*b.
// Sits beside the ALU for MUL/MULS; busy holds the control FSM, done strobes the write-back.
module mul_seq #(
    parameter int WIDTH      = 32,
    parameter int EARLY_TERM = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             flush,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product,
    output logic             n_flag,
    output logic             z_flag
);

    localparam int CW = $clog2(WIDTH) + 1;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

    localparam logic [CW-1:0]    CNT_ZERO  = CW'(0);
    localparam logic [CW-1:0]    CNT_ONE   = CW'(1);
    localparam logic [CW-1:0]    CNT_LAST  = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] DATA_ZERO = {WIDTH{1'b0}};

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [WIDTH-1:0] r_acc;
    logic [CW-1:0]    r_cnt;

    logic [1:0]       w_state_nxt;
    logic [WIDTH-1:0] w_mcand_nxt;
    logic [WIDTH-1:0] w_mplier_nxt;
    logic [WIDTH-1:0] w_acc_nxt;
    logic [CW-1:0]    w_cnt_nxt;
    logic             w_last;

    // Final iteration: full count reached, or (optionally) no multiplier bits left after this step.
    assign w_last = (r_cnt == CNT_LAST) ||
                    ((EARLY_TERM != 0) && ((r_mplier >> 1) == DATA_ZERO));

    // Next-state and datapath update; flush outranks everything including start.
    always_comb begin
        w_state_nxt  = r_state;
        w_mcand_nxt  = r_mcand;
        w_mplier_nxt = r_mplier;
        w_acc_nxt    = r_acc;
        w_cnt_nxt    = r_cnt;
        if (flush) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = CNT_ZERO;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        w_mcand_nxt  = a;
                        w_mplier_nxt = b;
                        w_acc_nxt    = DATA_ZERO;
                        w_cnt_nxt    = CNT_ZERO;
                        w_state_nxt  = ST_RUN;
                    end else begin
                        w_state_nxt  = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (r_mplier[0]) begin
                        w_acc_nxt = r_acc + r_mcand;
                    end else begin
                        w_acc_nxt = r_acc;
                    end
                    w_mcand_nxt  = r_mcand << 1;
                    w_mplier_nxt = r_mplier >> 1;
                    w_cnt_nxt    = r_cnt + CNT_ONE;
                    if (w_last) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_state_nxt = ST_RUN;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= ST_IDLE;
            r_mcand  <= DATA_ZERO;
            r_mplier <= DATA_ZERO;
            r_acc    <= DATA_ZERO;
            r_cnt    <= CNT_ZERO;
        end else begin
            r_state  <= w_state_nxt;
            r_mcand  <= w_mcand_nxt;
            r_mplier <= w_mplier_nxt;
            r_acc    <= w_acc_nxt;
            r_cnt    <= w_cnt_nxt;
        end
    end

    assign busy    = (r_state == ST_RUN);
    assign done    = (r_state == ST_DONE);
    assign product = r_acc;
    assign n_flag  = r_acc[WIDTH-1];
    assign z_flag  = (r_acc == DATA_ZERO);

endmodule

// File: tb/tb_mul_seq.sv
// Directed bench for mul_seq: one instance per EARLY_TERM setting, sharing stimulus.
module tb_mul_seq;

    logic        clk;
    logic        reset;
    logic        start;
    logic        flush;
    logic [31:0] a;
    logic [31:0] b;

    logic        busy0, done0, n0, z0;
    logic [31:0] prod0;
    logic        busy1, done1, n1, z1;
    logic [31:0] prod1;

    int passed = 0;
    int total  = 0;
    int cyc;
    int bcnt;
    int dcnt;

    mul_seq #(.WIDTH(32), .EARLY_TERM(0)) u_full (
        .clk(clk), .reset(reset), .start(start), .flush(flush), .a(a), .b(b),
        .busy(busy0), .done(done0), .product(prod0), .n_flag(n0), .z_flag(z0)
    );

    mul_seq #(.WIDTH(32), .EARLY_TERM(1)) u_early (
        .clk(clk), .reset(reset), .start(start), .flush(flush), .a(a), .b(b),
        .busy(busy1), .done(done1), .product(prod1), .n_flag(n1), .z_flag(z1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic issue(input logic [31:0] va, input logic [31:0] vb);
        a     = va;
        b     = vb;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Called in cycle 1 after the start edge; returns the cycle index where done is seen.
    task automatic wait_done(input bit sel, output int c, output int nbusy);
        c     = 1;
        nbusy = 0;
        while (!(sel ? done1 : done0) && c < 100) begin
            if (sel ? busy1 : busy0) nbusy++;
            tick();
            c++;
        end
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        flush = 1'b0;
        a     = 32'd0;
        b     = 32'd0;
        tick();
        tick();
        check("rst_busy", {31'd0, busy0}, 32'd0);
        check("rst_done", {31'd0, done0}, 32'd0);
        check("rst_prod", prod0, 32'd0);
        check("rst_n",    {31'd0, n0}, 32'd0);
        check("rst_z",    {31'd0, z0}, 32'd1);
        reset = 1'b1;
        tick();

        // 7*6 on the full-length instance
        issue(32'd7, 32'd6);
        wait_done(1'b0, cyc, bcnt);
        check("lat_7x6",  cyc, 32'd33);
        check("busy_7x6", bcnt, 32'd32);
        check("prod_7x6", prod0, 32'd42);
        check("n_7x6",    {31'd0, n0}, 32'd0);
        check("z_7x6",    {31'd0, z0}, 32'd0);
        tick();
        check("post_busy", {31'd0, busy0}, 32'd0);
        check("post_done", {31'd0, done0}, 32'd0);

        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(1'b0, cyc, bcnt);
        check("prod_ones", prod0, 32'h0000_0001);
        check("n_ones",    {31'd0, n0}, 32'd0);
        tick();
        issue(32'h8000_0000, 32'd1);
        wait_done(1'b0, cyc, bcnt);
        check("lat_msb",  cyc, 32'd33);
        check("prod_msb", prod0, 32'h8000_0000);
        check("n_msb",    {31'd0, n0}, 32'd1);
        tick();

        // early-termination instance
        issue(32'h1234, 32'd0);
        wait_done(1'b1, cyc, bcnt);
        check("lat_b0",  cyc, 32'd2);
        check("prod_b0", prod1, 32'd0);
        check("z_b0",    {31'd0, z1}, 32'd1);
        tick();
        issue(32'h1234, 32'd5);
        wait_done(1'b1, cyc, bcnt);
        check("lat_b5",  cyc, 32'd4);
        check("prod_b5", prod1, 32'h5B04);
        tick();

        // start during RUN ignored, then back-to-back issue from DONE
        a = 32'd5; b = 32'd2; start = 1'b1;
        tick();
        a = 32'd9;
        tick();
        a = 32'd3; b = 32'd3;
        tick();
        check("b2b_done1", {31'd0, done1}, 32'd1);
        check("b2b_prod1", prod1, 32'd10);
        tick();
        start = 1'b0;
        check("b2b_busy", {31'd0, busy1}, 32'd1);
        wait_done(1'b1, cyc, bcnt);
        check("b2b_lat2",  cyc, 32'd3);
        check("b2b_prod2", prod1, 32'd9);

        // flush mid-operation on the full-length instance
        repeat (40) tick();
        issue(32'd7, 32'd6);
        repeat (9) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("fl_busy", {31'd0, busy0}, 32'd0);
        check("fl_done", {31'd0, done0}, 32'd0);
        dcnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (done0) dcnt++;
            tick();
        end
        check("fl_nodone", dcnt, 32'd0);
        issue(32'd2, 32'd5);
        wait_done(1'b0, cyc, bcnt);
        check("fl_lat",  cyc, 32'd33);
        check("fl_prod", prod0, 32'd10);
        tick();

        // asynchronous reset mid-operation
        issue(32'd7, 32'd6);
        repeat (5) tick();
        #2;
        reset = 1'b0;
        #1;
        check("ar_busy", {31'd0, busy0}, 32'd0);
        check("ar_done", {31'd0, done0}, 32'd0);
        check("ar_prod", prod0, 32'd0);
        check("ar_z",    {31'd0, z0}, 32'd1);
        reset = 1'b1;
        tick();
        issue(32'd11, 32'd11);
        wait_done(1'b0, cyc, bcnt);
        check("ar_prod2", prod0, 32'd121);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
